// File: rtl/fpu_f64_pkg.sv
// Shared binary64 field layout, special-value encodings and divider FSM states.
package fpu_f64_pkg;

  localparam int SIGN_BIT = 63;
  localparam int EXP_LSB  = 52;
  localparam int EXP_W    = 11;
  localparam int FRAC_W   = 52;
  localparam int MANT_W   = 53;
  localparam int REM_W    = 54;
  localparam int QUO_W    = 55;
  localparam int CNT_W    = 6;
  localparam int EXP_BIAS = 1023;

  localparam logic [EXP_W-1:0]  EXP_MAX   = 11'h7FF;
  localparam logic [FRAC_W-1:0] FRAC_NAN  = '1;
  localparam logic [FRAC_W-1:0] FRAC_INF  = '0;
  localparam logic [CNT_W-1:0]  LAST_STEP = 6'd54;

  typedef enum logic [1:0] {IDLE, CALC, NORM} fpu_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } f64_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } f64_class_t;

  // Denormals are treated as zero.
  function automatic f64_class_t classify(input f64_t x);
    f64_class_t c;
    c.nan  = (x.exp == EXP_MAX) && (x.frac != '0);
    c.inf  = (x.exp == EXP_MAX) && (x.frac == '0);
    c.zero = (x.exp == '0);
    return c;
  endfunction

endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division step: conditional subtract, quotient bit, shift left.
module fpu_div_step
  import fpu_f64_pkg::*;
(
  input  logic [REM_W-1:0]  rem_in,
  input  logic [MANT_W-1:0] divisor,
  output logic [REM_W-1:0]  rem_out,
  output logic              q_bit
);

  logic [REM_W-1:0] div_ext;
  logic [REM_W-1:0] diff;

  // After a subtract the remainder is below the divisor, so the shift never loses a bit.
  always_comb begin
    div_ext = {1'b0, divisor};
    q_bit   = (rem_in >= div_ext);
    diff    = q_bit ? (rem_in - div_ext) : rem_in;
    rem_out = diff << 1;
  end

endmodule

// File: rtl/fpu_divide_f64.sv
// Multi-cycle binary64 divider: specials resolve in IDLE, normals run 55 restoring
// steps in CALC followed by one NORM cycle for normalise/round/pack.
module fpu_divide_f64
  import fpu_f64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clean,
  input  logic        start,
  input  logic [63:0] num_a,
  input  logic [63:0] num_b,
  output logic [63:0] num_c,
  output logic        ready
);

  localparam logic signed [12:0] BIAS_HI = 13'(EXP_BIAS);
  localparam logic signed [12:0] BIAS_LO = 13'(EXP_BIAS - 1);
  localparam logic signed [12:0] EXP_TOP = 13'(2047);

  fpu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [MANT_W-1:0]  div_q, div_d;
  logic [QUO_W-1:0]   quo_q, quo_d;
  logic signed [12:0] exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [63:0]        num_c_q, num_c_d;

  f64_t       a_w, b_w;
  f64_class_t ca, cb;
  logic       sign_in, is_nan, is_inf, is_zero, special;
  logic [63:0] spec_res;

  logic [REM_W-1:0] step_rem;
  logic             step_bit;

  logic [FRAC_W-1:0]  mant_sel;
  logic               rnd_bit;
  logic [FRAC_W:0]    mant_rnd;
  logic signed [12:0] exp_norm, exp_fin;
  logic [63:0]        norm_res;

  assign a_w = num_a;
  assign b_w = num_b;
  assign ca  = classify(a_w);
  assign cb  = classify(b_w);

  always_comb begin
    sign_in  = a_w.sign ^ b_w.sign;
    is_nan   = ca.nan | cb.nan | (ca.zero & cb.zero) | (ca.inf & cb.inf);
    is_inf   = ca.inf | cb.zero;
    is_zero  = ca.zero | cb.inf;
    special  = is_nan | is_inf | is_zero;
    if (is_nan)
      spec_res = {sign_in, EXP_MAX, FRAC_NAN};
    else if (is_inf)
      spec_res = {sign_in, EXP_MAX, FRAC_INF};
    else
      spec_res = {sign_in, {(EXP_W + FRAC_W){1'b0}}};
  end

  fpu_div_step u_step (
    .rem_in  (rem_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // Quotient lies in (0.5, 2): the top bit decides which window is the mantissa.
  always_comb begin
    if (quo_q[QUO_W-1]) begin
      mant_sel = quo_q[53:2];
      rnd_bit  = quo_q[1];
      exp_norm = exp_q + BIAS_HI;
    end else begin
      mant_sel = quo_q[52:1];
      rnd_bit  = quo_q[0];
      exp_norm = exp_q + BIAS_LO;
    end
    mant_rnd = {1'b0, mant_sel} + {{FRAC_W{1'b0}}, rnd_bit};
    exp_fin  = exp_norm + $signed({12'd0, mant_rnd[FRAC_W]});
    if (exp_fin <= 13'sd0)
      norm_res = {sign_q, {(EXP_W + FRAC_W){1'b0}}};
    else if (exp_fin >= EXP_TOP)
      norm_res = {sign_q, EXP_MAX, FRAC_INF};
    else
      norm_res = {sign_q, exp_fin[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    num_c_d = num_c_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (special) begin
            num_c_d = spec_res;
          end else begin
            sign_d  = sign_in;
            rem_d   = {2'b01, a_w.frac};
            div_d   = {1'b1, b_w.frac};
            exp_d   = $signed({2'b00, a_w.exp}) - $signed({2'b00, b_w.exp});
            quo_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[QUO_W-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        num_c_d = norm_res;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clean) begin
      state_d = IDLE;
      cnt_d   = '0;
      rem_d   = '0;
      div_d   = '0;
      quo_d   = '0;
      exp_d   = '0;
      sign_d  = 1'b0;
      num_c_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      num_c_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      num_c_q <= num_c_d;
    end
  end

  assign num_c = num_c_q;
  assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_fpu_divide_f64.sv
// Bench for fpu_divide_f64: directed vector table, abort sequences and random
// operands checked against an integer long-division reference.
module tb_fpu_divide_f64;

  logic        clk, rst, clean, start, ready;
  logic [63:0] num_a, num_b, num_c;

  int errors = 0;
  int checks = 0;

  fpu_divide_f64 dut (
    .clk   (clk),
    .rst   (rst),
    .clean (clean),
    .start (start),
    .num_a (num_a),
    .num_b (num_b),
    .num_c (num_c),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic is_special(input logic [63:0] a, input logic [63:0] b);
    return (a[62:52] == 11'h7FF) || (b[62:52] == 11'h7FF) ||
           (a[62:52] == 11'h000) || (b[62:52] == 11'h000);
  endfunction

  // Exact quotient via wide integer division, round to nearest, flush tiny, saturate huge.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
    logic         s, na, nb, ia, ib, za, zb, r;
    int           ea, eb, e;
    logic [127:0] qq, m;
    s  = a[63] ^ b[63];
    ea = int'(a[62:52]);
    eb = int'(b[62:52]);
    na = (ea == 2047) && (a[51:0] != 0);
    nb = (eb == 2047) && (b[51:0] != 0);
    ia = (ea == 2047) && (a[51:0] == 0);
    ib = (eb == 2047) && (b[51:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (za && zb) || (ia && ib)) return {s, 11'h7FF, {52{1'b1}}};
    if (ia || zb) return {s, 11'h7FF, 52'h0};
    if (za || ib) return {s, 63'h0};
    qq = ({75'h0, 1'b1, a[51:0]} << 60) / {75'h0, 1'b1, b[51:0]};
    e  = ea - eb + 1022;
    if (qq[60]) begin
      e++;
      m = qq >> 8;
      r = qq[7];
    end else begin
      m = qq >> 7;
      r = qq[6];
    end
    m = m + {127'h0, r};
    if (m[53]) begin
      m = m >> 1;
      e++;
    end
    if (e <= 0) return {s, 63'h0};
    if (e >= 2047) return {s, 11'h7FF, 52'h0};
    return {s, e[10:0], m[51:0]};
  endfunction

  // Starts an op at the current (mid-cycle) time; returns result, edges until ready, busy samples.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit hold,
                       output logic [63:0] res, output int lat, output int low);
    num_a = a;
    num_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    low = 0;
    if (!hold) start = 1'b0;
    while (!ready && lat < 200) begin
      low++;
      num_a = {$urandom, $urandom};
      num_b = {$urandom, $urandom};
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    res = num_c;
  endtask

  localparam logic [63:0] SIX = 64'h4018000000000000;
  localparam logic [63:0] TWO = 64'h4000000000000000;
  localparam logic [63:0] THR = 64'h4008000000000000;

  vec_t        vt[11];
  logic [63:0] res, a, b;
  int          lat, low;

  initial begin
    rst   = 1'b0;
    clean = 1'b0;
    start = 1'b0;
    num_a = '0;
    num_b = '0;

    vt[0]  = '{"div_6_2",      SIX, TWO, THR, 57};
    vt[1]  = '{"div_1_3",      64'h3FF0000000000000, THR, 64'h3FD5555555555555, 57};
    vt[2]  = '{"div_m1_2",     64'hBFF0000000000000, TWO, 64'hBFE0000000000000, 57};
    vt[3]  = '{"div_1_0",      64'h3FF0000000000000, 64'h0, 64'h7FF0000000000000, 1};
    vt[4]  = '{"div_0_0",      64'h0, 64'h0, 64'h7FFFFFFFFFFFFFFF, 1};
    vt[5]  = '{"div_2_inf",    TWO, 64'h7FF0000000000000, 64'h0, 1};
    vt[6]  = '{"overflow",     64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 57};
    vt[7]  = '{"nan_operand",  64'h7FF8000000000000, 64'h3FF0000000000000, 64'h7FFFFFFFFFFFFFFF, 1};
    vt[8]  = '{"minf_inf",     64'hFFF0000000000000, 64'h7FF0000000000000, 64'hFFFFFFFFFFFFFFFF, 1};
    vt[9]  = '{"underflow",    64'h0010000000000000, TWO, 64'h0, 57};
    vt[10] = '{"denorm_a",     64'h8000000000000001, TWO, 64'h8000000000000000, 1};

    #1;
    check("reset_ready", {63'h0, ready}, 64'h1);
    check("reset_num_c", num_c, 64'h0);

    // Accept on the first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    do_op(SIX, TWO, 1'b0, res, lat, low);
    check("post_reset_res", res, THR);
    check("post_reset_lat", 64'(lat), 64'd57);
    check("post_reset_low", 64'(low), 64'd56);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    num_a = SIX; num_b = TWO; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_abort_busy", {63'h0, ready}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_abort_ready", {63'h0, ready}, 64'h1);
    check("rst_abort_num_c", num_c, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    do_op(SIX, TWO, 1'b0, res, lat, low);
    check("rst_abort_redo", res, THR);

    // Synchronous clean in the middle of CALC.
    @(negedge clk);
    num_a = SIX; num_b = TWO; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("clean_abort_busy", {63'h0, ready}, 64'h0);
    clean = 1'b1;
    @(posedge clk);
    #1;
    check("clean_abort_ready", {63'h0, ready}, 64'h1);
    check("clean_abort_num_c", num_c, 64'h0);
    @(negedge clk);
    clean = 1'b0;
    do_op(SIX, TWO, 1'b0, res, lat, low);
    check("clean_abort_redo", res, THR);

    foreach (vt[i]) begin
      @(negedge clk);
      do_op(vt[i].a, vt[i].b, 1'b0, res, lat, low);
      check(vt[i].name, res, vt[i].c);
      check({vt[i].name, "_lat"}, 64'(lat), 64'(vt[i].lat));
      check({vt[i].name, "_low"}, 64'(low), 64'(vt[i].lat - 1));
    end

    // start held high with changing operands while busy must be ignored.
    @(negedge clk);
    do_op(SIX, TWO, 1'b1, res, lat, low);
    check("hold_start_res", res, THR);
    check("hold_start_lat", 64'(lat), 64'd57);

    for (int i = 0; i < 150; i++) begin
      if (i % 4 == 0) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end else begin
        a = {1'($urandom), 11'($urandom_range(900, 1150)), $urandom, 20'($urandom)};
        b = {1'($urandom), 11'($urandom_range(900, 1150)), $urandom, 20'($urandom)};
      end
      if (i % 16 == 5) a[62:52] = 11'h000;
      if (i % 16 == 9) b[62:52] = 11'h7FF;
      @(negedge clk);
      do_op(a, b, 1'b0, res, lat, low);
      check($sformatf("rand%0d_%h_%h", i, a, b), res, ref_div(a, b));
      check($sformatf("rand%0d_lat", i), 64'(lat), is_special(a, b) ? 64'd1 : 64'd57);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_divide_f64.md
FPU_DIVIDE_F64 -- requirements
Module: fpu_divide_f64

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port clean, input, 1: synchronous abort, active-high.
REQ-004 SHALL have port start, input, 1: request; accepted only when ready=1.
REQ-005 SHALL have port num_a, input, 64: IEEE-754 binary64 dividend.
REQ-006 SHALL have port num_b, input, 64: IEEE-754 binary64 divisor.
REQ-007 SHALL have port num_c, output, 64: registered quotient; holds until the next accepted start.
REQ-008 SHALL have port ready, output, 1: high when idle and able to accept start.

Function
REQ-009 SHALL implement states IDLE, CALC and NORM; ready=1 only in IDLE.
REQ-010 SHALL, on an edge with start=1 and ready=1 and a special operand case, write the special result to num_c on that edge and stay in IDLE; ready stays 1.
REQ-011 SHALL classify operands as follows: exponent 0x7FF with fraction!=0 is NaN; exponent 0x7FF with fraction 0 is inf; exponent 0 is zero (denormals flush to zero).
REQ-012 SHALL give these special results, sign = sign_a ^ sign_b in every case:
- NaN operand, 0/0 or inf/inf -> exponent and fraction all ones.
- inf/x or x/0 -> exponent 0x7FF, fraction 0.
- 0/x or x/inf -> all zero below the sign bit.
REQ-013 SHALL, on an edge accepting a normal case, latch sign, mantissas {1,frac_a} and {1,frac_b} (53 bits), and exponent e = exp_a - exp_b as 13-bit signed; then enter CALC with counter 0.
REQ-014 SHALL in CALC perform one restoring-division step per cycle: if remainder >= divisor, subtract and shift in quotient bit 1, else shift in 0; remainder then shifts left 1.
REQ-015 SHALL run CALC for exactly 55 cycles (counter 0..54) producing q[54:0], then move to NORM.
REQ-016 SHALL normalise in NORM:
- If q[54]=1: mantissa q[53:2], round bit q[1], exponent e+1023.
- Otherwise: mantissa q[52:1], round bit q[0], exponent e+1022.
REQ-017 SHALL round half-up by adding the round bit to the mantissa; a carry out of the mantissa increments the exponent and clears the fraction.
REQ-018 SHALL write signed zero when the final exponent <= 0 and inf (exponent 0x7FF, fraction 0) when it >= 2047; otherwise it packs sign/exponent/fraction.
REQ-019 SHALL register num_c on the NORM edge and return to IDLE; ready reasserts after the 57th rising edge, counting the accepting edge as the 1st.
REQ-020 SHALL ignore start while ready=0; num_a and num_b may change freely after acceptance.
REQ-021 SHALL give clean priority over start: clean=1 forces IDLE, counter 0, ready 1, num_c 0 on that edge, including mid-operation.

Reset
REQ-022 SHALL on rst=0 immediately set state IDLE, counter 0, ready 1, num_c 0 and clear all datapath registers; reset mid-operation discards the operation.
REQ-023 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-024 SHALL take the following from shared package fpu_f64_pkg: SIGN_BIT=63, EXP_LSB=52, EXP_W=11, EXP_BIAS=1023, EXP_MAX=11'h7FF, the NaN/inf field patterns and the state enum.
REQ-025 SHALL use one combinational sub-module fpu_div_step (compare/subtract/shift of the 54-bit remainder, 1 quotient bit); no other sub-modules.
REQ-026 SHALL keep the counter at 6 bits and the remainder register at 54 bits.

Verification
REQ-027 SHALL cover 6.0/2.0: 0x4018000000000000 / 0x4000000000000000 -> num_c=0x4008000000000000, with ready low for exactly 56 cycles.
REQ-028 SHALL cover 1.0/3.0: 0x3FF0000000000000 / 0x4008000000000000 -> 0x3FD5555555555555.
REQ-029 SHALL cover -1.0/2.0: 0xBFF0000000000000 / 0x4000000000000000 -> 0xBFE0000000000000.
REQ-030 SHALL cover specials, one cycle each with ready never low:
- 1.0/0.0 -> 0x7FF0000000000000.
- 0.0/0.0 -> 0x7FFFFFFFFFFFFFFF.
- 2.0/inf -> 0x0000000000000000.
REQ-031 SHALL cover overflow: 0x7FE0000000000000 / 0x3FE0000000000000 -> 0x7FF0000000000000 after the full 57-edge latency.
REQ-032 SHALL cover abort: start 6.0/2.0, then drive rst=0 at CALC cycle 20 (and separately clean=1) -> ready=1 and num_c=0 at once; a following 6.0/2.0 gives 0x4008000000000000.
